// File: rtl/pixel_pkg.sv
// Shared framebuffer geometry, FIFO entry layout and address helper for the pixel write path.
package pixel_pkg;

    localparam int FB_W      = 160;
    localparam int FB_H      = 120;
    localparam int FB_ADDR_W = 15;
    localparam int RGB_W     = 9;

    typedef struct packed {
        logic [FB_ADDR_W-1:0] addr;
        logic [RGB_W-1:0]     rgb;
    } fb_entry_t;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } wb_state_e;

    function automatic logic [FB_ADDR_W-1:0] pixel_addr(
        input logic [7:0] x,
        input logic [7:0] y,
        input int         width
    );
        return FB_ADDR_W'(y) * FB_ADDR_W'(width) + FB_ADDR_W'(x);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Register-array FIFO; head is visible the cycle after the first push, pop frees a slot on the same edge.
// Pushes while full and pops while empty are ignored; the caller applies backpressure from full_o.
module sync_fifo #(
    parameter  int WIDTH = 24,
    parameter  int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic [LVL_W-1:0] level_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0] level_q, level_d;
    logic             push_ok, pop_ok;

    assign full_o  = (level_q == LVL_W'(DEPTH));
    assign empty_o = (level_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];
    assign level_o = level_q;

    always_comb begin
        level_d = level_q;
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_d;
        end
    end

    // Storage needs no reset: nothing is read until level_q says it was written.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
    end

endmodule

// File: rtl/pixel_write_buffer.sv
// Pixel write buffer: range-checks and linearises (x,y), queues in a FIFO, drains on fb_ready_i; head shows 1 cycle after accept.
// in_ready_o drops when full (no same-cycle bypass); FB_CLEAR_EN adds a post-reset framebuffer clear sweep.
module pixel_write_buffer #(
    parameter  int FB_W  = pixel_pkg::FB_W,
    parameter  int FB_H  = pixel_pkg::FB_H,
    parameter  int DEPTH = 16,
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [7:0]       in_x_i,
    input  logic [7:0]       in_y_i,
    input  logic [2:0]       in_r_i,
    input  logic [2:0]       in_g_i,
    input  logic [2:0]       in_b_i,
    output logic             fb_we_o,
    input  logic             fb_ready_i,
    output logic [14:0]      fb_addr_o,
    output logic [8:0]       fb_data_o,
    output logic [LVL_W-1:0] level_o,
    output logic [7:0]       oob_count_o,
    output logic             busy_o
);

    import pixel_pkg::*;

    logic      run;
    logic      accept, oob, push, pop;
    logic      full, empty;
    fb_entry_t push_entry, head;
    logic [7:0] oob_count_q, oob_count_d;

`ifdef FB_CLEAR_EN
    wb_state_e            state_q, state_d;
    logic [FB_ADDR_W-1:0] sweep_q, sweep_d;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= ST_CLEAR;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        if (state_q == ST_CLEAR && fb_ready_i) begin
            if (sweep_q == FB_ADDR_W'(FB_W * FB_H - 1)) begin
                state_d = ST_RUN;
                sweep_d = '0;
            end else begin
                sweep_d = sweep_q + 1'b1;
            end
        end
    end

    assign run = (state_q == ST_RUN);
`else
    assign run = 1'b1;
`endif

    assign in_ready_o      = run && !full;
    assign accept          = in_valid_i && in_ready_o;
    assign oob             = (int'(in_x_i) >= FB_W) || (int'(in_y_i) >= FB_H);
    assign push            = accept && !oob;
    assign pop             = run && !empty && fb_ready_i;
    assign push_entry.addr = pixel_addr(in_x_i, in_y_i, FB_W);
    assign push_entry.rgb  = {in_r_i, in_g_i, in_b_i};

    sync_fifo #(
        .WIDTH ($bits(fb_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i      (clock_i),
        .reset_i    (reset_i),
        .push_i     (push),
        .push_dat_i (push_entry),
        .pop_i      (pop),
        .head_o     (head),
        .level_o    (level_o),
        .full_o     (full),
        .empty_o    (empty)
    );

    always_comb begin
        oob_count_d = oob_count_q;
        if (accept && oob && oob_count_q != 8'hFF) oob_count_d = oob_count_q + 1'b1;
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) oob_count_q <= '0;
        else         oob_count_q <= oob_count_d;
    end

    assign oob_count_o = oob_count_q;

    // Idle outputs are forced to zero so the port never exposes stale array contents.
    always_comb begin
        fb_we_o   = run && !empty;
        fb_addr_o = empty ? '0 : head.addr;
        fb_data_o = empty ? '0 : head.rgb;
        busy_o    = !run || !empty;
`ifdef FB_CLEAR_EN
        if (!run) begin
            fb_we_o   = 1'b1;
            fb_addr_o = sweep_q;
            fb_data_o = '0;
        end
`endif
    end

endmodule

// File: tb/tb_pixel_write_buffer.sv
// Bench for pixel_write_buffer: vector table, hand sequences and a randomized run against a queue-based model.
module tb_pixel_write_buffer;

`ifdef FB_CLEAR_EN
    localparam bit CLR_BUILD = 1'b1;
`else
    localparam bit CLR_BUILD = 1'b0;
`endif

    logic       clock_i = 1'b0;
    logic       reset_i = 1'b1;
    logic       in_valid_i = 1'b0;
    logic       in_ready_o;
    logic [7:0] in_x_i = '0, in_y_i = '0;
    logic [2:0] in_r_i = '0, in_g_i = '0, in_b_i = '0;
    logic       fb_we_o;
    logic       fb_ready_i = 1'b0;
    logic [14:0] fb_addr_o;
    logic [8:0] fb_data_o;
    logic [4:0] level_o;
    logic [7:0] oob_count_o;
    logic       busy_o;

    int  checks = 0, failures = 0;
    bit  chk_en = 1'b0;

    always #5 clock_i = ~clock_i;

    pixel_write_buffer dut (
        .clock_i     (clock_i),
        .reset_i     (reset_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_x_i      (in_x_i),
        .in_y_i      (in_y_i),
        .in_r_i      (in_r_i),
        .in_g_i      (in_g_i),
        .in_b_i      (in_b_i),
        .fb_we_o     (fb_we_o),
        .fb_ready_i  (fb_ready_i),
        .fb_addr_o   (fb_addr_o),
        .fb_data_o   (fb_data_o),
        .level_o     (level_o),
        .oob_count_o (oob_count_o),
        .busy_o      (busy_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // Reference model: the buffer is a queue of pending writes in accept order.
    int q_addr[$];
    int q_data[$];
    int oob_m = 0;
    bit clr_m = 1'b0;
    int clr_addr_m = 0;

    always @(posedge clock_i) begin : model
        bit acc, pop, out_of_range;
        int tmp;
        if (reset_i) begin
            q_addr.delete();
            q_data.delete();
            oob_m      = 0;
            clr_m      = CLR_BUILD;
            clr_addr_m = 0;
        end else if (clr_m) begin
            if (fb_ready_i) begin
                if (clr_addr_m == 19199) clr_m = 1'b0;
                else                     clr_addr_m++;
            end
        end else begin
            acc = in_valid_i && (q_addr.size() < 16);
            pop = (q_addr.size() != 0) && fb_ready_i;
            out_of_range = (int'(in_x_i) >= 160) || (int'(in_y_i) >= 120);
            if (pop) begin
                tmp = q_addr.pop_front();
                tmp = q_data.pop_front();
            end
            if (acc) begin
                if (out_of_range) begin
                    if (oob_m < 255) oob_m++;
                end else begin
                    q_addr.push_back(int'(in_y_i) * 160 + int'(in_x_i));
                    q_data.push_back(int'(in_r_i) * 64 + int'(in_g_i) * 8 + int'(in_b_i));
                end
            end
        end
    end

    always @(negedge clock_i) begin
        if (chk_en && !reset_i) begin
            if (clr_m) begin
                chk("clr_in_ready", in_ready_o, 0);
                chk("clr_we", fb_we_o, 1);
                chk("clr_addr", fb_addr_o, clr_addr_m);
                chk("clr_data", fb_data_o, 0);
                chk("clr_busy", busy_o, 1);
            end else begin
                chk("level", level_o, q_addr.size());
                chk("in_ready", in_ready_o, q_addr.size() < 16);
                chk("fb_we", fb_we_o, q_addr.size() != 0);
                chk("busy", busy_o, q_addr.size() != 0);
                chk("oob_count", oob_count_o, oob_m);
                if (q_addr.size() != 0) begin
                    chk("fb_addr", fb_addr_o, q_addr[0]);
                    chk("fb_data", fb_data_o, q_data[0]);
                end
            end
        end
    end

    // Drives one pixel from a falling edge and returns at the falling edge after it was accepted.
    task automatic send(input int x, input int y, input int r, input int g, input int b);
        int n = 0;
        in_x_i = 8'(x); in_y_i = 8'(y);
        in_r_i = 3'(r); in_g_i = 3'(g); in_b_i = 3'(b);
        in_valid_i = 1'b1;
        while (!in_ready_o && n < 200) begin
            @(negedge clock_i);
            n++;
        end
        if (n >= 200) timeout_fail("send");
        @(posedge clock_i);
        @(negedge clock_i);
    endtask

    task automatic wait_clear(input int ready_pct);
        int n = 0;
        while (clr_m && n < 60000) begin
            fb_ready_i = ($urandom_range(0, 99) < ready_pct);
            @(negedge clock_i);
            n++;
        end
        if (clr_m) timeout_fail("clear_sweep");
    endtask

    task automatic do_reset();
        @(negedge clock_i);
        in_valid_i = 1'b0;
        reset_i = 1'b1;
        @(negedge clock_i);
        reset_i = 1'b0;
        wait_clear(100);
    endtask

    task automatic drain();
        int n = 0;
        in_valid_i = 1'b0;
        fb_ready_i = 1'b1;
        while (q_addr.size() != 0 && n < 100) begin
            @(negedge clock_i);
            n++;
        end
        if (q_addr.size() != 0) timeout_fail("drain");
        chk("drain_level", level_o, 0);
    endtask

    typedef struct {
        int x, y, r, g, b;
        int we;
        int addr;
        int data;
    } vec_t;

    vec_t tbl[7];

    initial begin
        tbl[0] = '{x:3,   y:2,   r:7, g:0, b:5, we:1, addr:323,   data:9'b111_000_101};
        tbl[1] = '{x:159, y:119, r:1, g:2, b:3, we:1, addr:19199, data:9'b001_010_011};
        tbl[2] = '{x:0,   y:0,   r:0, g:0, b:0, we:1, addr:0,     data:0};
        tbl[3] = '{x:7,   y:100, r:4, g:4, b:4, we:1, addr:16007, data:9'b100_100_100};
        tbl[4] = '{x:160, y:0,   r:7, g:7, b:7, we:0, addr:0,     data:0};
        tbl[5] = '{x:0,   y:120, r:7, g:7, b:7, we:0, addr:0,     data:0};
        tbl[6] = '{x:255, y:255, r:1, g:1, b:1, we:0, addr:0,     data:0};

        repeat (2) @(negedge clock_i);
        reset_i = 1'b0;
        chk("rst_level", level_o, 0);
        chk("rst_oob", oob_count_o, 0);
        chk("rst_addr", fb_addr_o, 0);
        chk("rst_data", fb_data_o, 0);
`ifdef FB_CLEAR_EN
        chk("rst_in_ready", in_ready_o, 0);
        chk("rst_busy", busy_o, 1);
        chk("rst_we", fb_we_o, 1);
        chk_en = 1'b1;
        begin
            int n = 0;
            fb_ready_i = 1'b1;
            while (clr_addr_m != 5000 && n < 10000) begin
                @(negedge clock_i);
                n++;
            end
            if (clr_addr_m != 5000) timeout_fail("sweep_to_5000");
            chk("sweep_at_5000", fb_addr_o, 5000);
            reset_i = 1'b1;
            @(negedge clock_i);
            reset_i = 1'b0;
            chk("sweep_restart", fb_addr_o, 0);
        end
        wait_clear(75);
`else
        chk("rst_in_ready", in_ready_o, 1);
        chk("rst_busy", busy_o, 0);
        chk("rst_we", fb_we_o, 0);
        chk_en = 1'b1;
`endif

        fb_ready_i = 1'b1;
        for (int i = 0; i < 7; i++) begin
            send(tbl[i].x, tbl[i].y, tbl[i].r, tbl[i].g, tbl[i].b);
            in_valid_i = 1'b0;
            chk("vec_we", fb_we_o, tbl[i].we);
            if (tbl[i].we != 0) begin
                chk("vec_addr", fb_addr_o, tbl[i].addr);
                chk("vec_data", fb_data_o, tbl[i].data);
            end
            @(negedge clock_i);
            chk("vec_level", level_o, 0);
        end

        // Full and release: sixteen held, seventeenth waits for the first pop.
        fb_ready_i = 1'b0;
        for (int i = 0; i < 16; i++) send(i, i, i % 8, (i + 1) % 8, (i + 2) % 8);
        in_x_i = 8'd20; in_y_i = 8'd20; in_valid_i = 1'b1;
        repeat (3) @(negedge clock_i);
        chk("full_level", level_o, 16);
        chk("full_in_ready", in_ready_o, 0);
        chk("full_head", fb_addr_o, 0);
        fb_ready_i = 1'b1;
        send(20, 20, 1, 1, 1);
        in_valid_i = 1'b0;
        drain();

        // Out-of-range pixels count and saturate.
        do_reset();
        fb_ready_i = 1'b1;
        send(160, 0, 1, 1, 1);
        send(0, 120, 1, 1, 1);
        in_valid_i = 1'b0;
        @(negedge clock_i);
        chk("oob_two", oob_count_o, 2);
        chk("oob_no_we", fb_we_o, 0);
        for (int i = 0; i < 300; i++) begin
            if (i % 2 == 0) send($urandom_range(160, 255), $urandom_range(0, 255), 0, 0, 0);
            else            send($urandom_range(0, 255), $urandom_range(120, 255), 0, 0, 0);
        end
        in_valid_i = 1'b0;
        @(negedge clock_i);
        chk("oob_sat", oob_count_o, 255);

        // Simultaneous push and pop hold the level.
        fb_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) send(10 + i, 50, 2, 3, 4);
        in_valid_i = 1'b0;
        @(negedge clock_i);
        chk("pp_level_start", level_o, 5);
        fb_ready_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_x_i = 8'(30 + i); in_y_i = 8'(60); in_valid_i = 1'b1;
            @(posedge clock_i);
            @(negedge clock_i);
            chk("pp_level", level_o, 5);
        end
        drain();

        // Randomized traffic with one reset in the middle.
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            in_valid_i = ($urandom_range(0, 99) < 60);
            in_x_i = 8'($urandom_range(0, 170));
            in_y_i = 8'($urandom_range(0, 125));
            in_r_i = 3'($urandom); in_g_i = 3'($urandom); in_b_i = 3'($urandom);
            fb_ready_i = ($urandom_range(0, 99) < 55);
            @(negedge clock_i);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
